// File: rtl/avmm_reader_pkg.sv
// Shared types and constants for the Avalon-MM block reader.
// Holds the reader FSM state type, the default address width and FIFO
// depth, and the data-path width.
package avmm_reader_pkg;

    localparam int unsigned DEF_ADDR_W     = 15;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DATA_W         = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/avmm_block_reader_if.sv
// Bundles the control, Avalon-MM master and stream source signals of the
// block reader.
//   control : start, base_addr, length -> busy, done
//   avm     : avm_address, avm_chipselect, avm_read, avm_write,
//             avm_byteenable, avm_writedata -> slave; avm_readdata <- slave
//   stream  : src_data, src_valid -> sink; src_ready <- sink
// modport master = reader side, modport slave = environment side.
interface avmm_block_reader_if
    import avmm_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     length;
    logic                busy;
    logic                done;

    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_read;
    logic                avm_write;
    logic [3:0]          avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;

    logic [DATA_W-1:0]   src_data;
    logic                src_valid;
    logic                src_ready;

    modport master (
        input  start, base_addr, length, avm_readdata, src_ready,
        output busy, done, avm_address, avm_chipselect, avm_read, avm_write,
               avm_byteenable, avm_writedata, src_data, src_valid
    );

    modport slave (
        output start, base_addr, length, avm_readdata, src_ready,
        input  busy, done, avm_address, avm_chipselect, avm_read, avm_write,
               avm_byteenable, avm_writedata, src_data, src_valid
    );

endinterface

// File: rtl/avmm_reader_fifo.sv
// Synchronous first-word-fall-through FIFO: rdata always shows the head
// entry, count gives the occupancy. DEPTH must be a power of two so the
// pointers wrap naturally. Caller guarantees no push when full and no
// pop when empty.
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : write one word
//   pop        : drop the head word
//   rdata      : head word
//   count      : number of stored words
module avmm_reader_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers and occupancy; a simultaneous push and pop leaves count as is.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/avmm_block_reader.sv
// Reads a block of consecutive words from an Avalon-MM slave with fixed
// read latency and streams them out in address order through a small FWFT
// buffer. Reads are only issued while the buffer has guaranteed room.
//   clk, reset : clock, synchronous active-high reset
//   bus.start/base_addr/length : block request (accepted when idle)
//   bus.busy/done              : block in progress / completion pulse
//   bus.avm_*                  : read-only Avalon-MM master
//   bus.src_*                  : valid/ready stream source
module avmm_block_reader
    import avmm_reader_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input logic                 clk,
    input logic                 reset,
    avmm_block_reader_if.master bus
);

    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRD_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    state_t                  state;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        issued_q;
    logic                    rd_q;
    logic                    busy_q;
    logic                    done_q;
    logic [READ_LATENCY-1:0] pipe_q;

    logic [FCNT_W-1:0]       fifo_count;
    logic [DATA_W-1:0]       fifo_head;
    logic                    push_c;
    logic                    pop_c;
    logic [CRD_W-1:0]        pending_c;
    logic                    credit_c;
    logic                    drained_c;

    // Returning data lands in the buffer as its latency bit leaves the pipe.
    assign push_c = pipe_q[READ_LATENCY-1];
    assign pop_c  = (fifo_count != '0) && bus.src_ready;

    // Words held plus words still on their way (including the read on the bus).
    assign pending_c = CRD_W'(fifo_count) + CRD_W'(rd_q) + CRD_W'($countones(pipe_q));
    assign credit_c  = pending_c < CRD_W'(FIFO_DEPTH);

    // Nothing in flight and the buffer is, or is just becoming, empty.
    assign drained_c = !rd_q && (pipe_q == '0) &&
                       ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && pop_c));

    // Block sequencer; the first read goes out on the accept edge since the
    // buffer is always empty while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pipe_q   <= '0;
        end else begin
            done_q <= 1'b0;
            pipe_q <= READ_LATENCY'({pipe_q, rd_q});
            case (state)
                IDLE: begin
                    rd_q <= 1'b0;
                    if (bus.start) begin
                        base_q <= bus.base_addr;
                        len_q  <= bus.length;
                        addr_q <= bus.base_addr;
                        busy_q <= 1'b1;
                        if (bus.length == '0) begin
                            issued_q <= '0;
                            state    <= DRAIN;
                        end else begin
                            issued_q <= LEN_W'(1);
                            rd_q     <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issued_q == len_q) begin
                        rd_q  <= 1'b0;
                        state <= DRAIN;
                    end else if (credit_c) begin
                        rd_q     <= 1'b1;
                        addr_q   <= base_q + issued_q[ADDR_W-1:0];
                        issued_q <= issued_q + LEN_W'(1);
                    end else begin
                        rd_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    rd_q <= 1'b0;
                    if (drained_c) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    rd_q  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    avmm_reader_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (bus.avm_readdata),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = rd_q;
    assign bus.avm_chipselect = rd_q;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_byteenable = 4'hF;
    assign bus.avm_writedata  = '0;
    assign bus.src_data       = fifo_head;
    assign bus.src_valid      = (fifo_count != '0);

endmodule

// File: tb/tb_avmm_block_reader.sv
// Bench for avmm_block_reader: a fixed-latency memory model answers reads,
// expected addresses and words are queued when a block is launched and
// checked as the DUT issues reads and streams words out.
module tb_avmm_block_reader;
    import avmm_reader_pkg::*;

    localparam int unsigned ADDR_W = DEF_ADDR_W;
    localparam int unsigned RL     = 1;
    localparam int unsigned DEPTH  = DEF_FIFO_DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    avmm_block_reader_if #(.ADDR_W(ADDR_W)) bus ();

    avmm_block_reader #(
        .ADDR_W       (ADDR_W),
        .READ_LATENCY (RL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int read_count = 0;
    int xfer_count = 0;
    int done_count = 0;

    logic [31:0]       mem_key = 32'h0;
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a, input logic [31:0] key);
        return 32'(a) ^ key;
    endfunction

    // Memory slave: data valid exactly RL cycles after the issue cycle.
    logic              rv [RL];
    logic [ADDR_W-1:0] ra [RL];
    always @(posedge clk) begin
        rv[0] <= bus.avm_read;
        ra[0] <= bus.avm_address;
        for (int i = 1; i < int'(RL); i++) begin
            rv[i] <= rv[i-1];
            ra[i] <= ra[i-1];
        end
    end
    assign bus.avm_readdata = (rv[RL-1] === 1'b1) ? mem_word(ra[RL-1], mem_key) : 32'hDEAD_BEEF;

    // Scoreboard monitor, sampled on the falling edge.
    logic              hold_q = 1'b0;
    logic [31:0]       hold_data;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       ed;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            total++;
            if (bus.avm_chipselect !== bus.avm_read) begin
                bad++;
                $display("FAIL chipselect: got %b want %b", bus.avm_chipselect, bus.avm_read);
            end
            if (bus.avm_read === 1'b1) begin
                read_count++;
                total++;
                if (exp_addr.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_read: got addr %h want no read", bus.avm_address);
                end else begin
                    ea = exp_addr.pop_front();
                    if (bus.avm_address !== ea) begin
                        bad++;
                        $display("FAIL read_addr: got %h want %h", bus.avm_address, ea);
                    end
                end
            end
            if (hold_q) begin
                total++;
                if (bus.src_data !== hold_data) begin
                    bad++;
                    $display("FAIL stall_stable: got %h want %h", bus.src_data, hold_data);
                end
            end
            if (bus.src_valid === 1'b1 && bus.src_ready === 1'b1) begin
                xfer_count++;
                total++;
                if (exp_data.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got %h want none", bus.src_data);
                end else begin
                    ed = exp_data.pop_front();
                    if (bus.src_data !== ed) begin
                        bad++;
                        $display("FAIL stream_data: got %h want %h", bus.src_data, ed);
                    end
                end
            end
            hold_q    = (bus.src_valid === 1'b1) && (bus.src_ready !== 1'b1);
            hold_data = bus.src_data;
            if (bus.done === 1'b1) begin
                done_count++;
                total++;
                if (exp_data.size() != 0 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL done_early: got words_left=%0d busy=%b want 0 0",
                             exp_data.size(), bus.busy);
                end
            end
        end else begin
            hold_q = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectations, then pulse start for one accept edge.
    task automatic launch(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + ADDR_W'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a, mem_key));
        end
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = len;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready, output bit seen);
        int d0;
        d0   = done_count;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            if (rand_ready) bus.src_ready = ($urandom_range(0, 1) == 1);
            step();
            if (done_count != d0) seen = 1'b1;
        end
        bus.src_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.src_ready = 1'b1;
        repeat (3) step();
        total++; if (bus.busy !== 1'b0)           begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0)           begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
        total++; if (bus.avm_read !== 1'b0)       begin bad++; $display("FAIL rst_read: got %b want 0", bus.avm_read); end
        total++; if (bus.avm_chipselect !== 1'b0) begin bad++; $display("FAIL rst_cs: got %b want 0", bus.avm_chipselect); end
        total++; if (bus.src_valid !== 1'b0)      begin bad++; $display("FAIL rst_valid: got %b want 0", bus.src_valid); end
        total++; if (bus.avm_write !== 1'b0)      begin bad++; $display("FAIL tie_write: got %b want 0", bus.avm_write); end
        total++; if (bus.avm_byteenable !== 4'hF) begin bad++; $display("FAIL tie_be: got %h want f", bus.avm_byteenable); end
        total++; if (bus.avm_writedata !== 32'h0) begin bad++; $display("FAIL tie_wdata: got %h want 0", bus.avm_writedata); end
        reset = 1'b0;
        step();
    endtask

    // base 0x10, length 4: cycle-exact read, stream and done timing.
    task automatic test_basic();
        logic [7:0] exp_rd   = 8'b0000_1111;
        logic [7:0] exp_vld  = 8'b0011_1100;
        logic [7:0] exp_done = 8'b0100_0000;
        logic [7:0] exp_busy = 8'b0011_1111;
        mem_key       = 32'h0;
        bus.src_ready = 1'b1;
        launch(15'h0010, 16'd4);
        for (int c = 0; c < 8; c++) begin
            total++; if (bus.avm_read !== exp_rd[c])    begin bad++; $display("FAIL basic_read c%0d: got %b want %b", c + 1, bus.avm_read, exp_rd[c]); end
            total++; if (bus.src_valid !== exp_vld[c])  begin bad++; $display("FAIL basic_valid c%0d: got %b want %b", c + 1, bus.src_valid, exp_vld[c]); end
            total++; if (bus.done !== exp_done[c])      begin bad++; $display("FAIL basic_done c%0d: got %b want %b", c + 1, bus.done, exp_done[c]); end
            total++; if (bus.busy !== exp_busy[c])      begin bad++; $display("FAIL basic_busy c%0d: got %b want %b", c + 1, bus.busy, exp_busy[c]); end
            step();
        end
        total++; if (exp_data.size() != 0) begin bad++; $display("FAIL basic_left: got %0d want 0", exp_data.size()); end
    endtask

    task automatic test_wrap();
        bit seen;
        mem_key = 32'h1234_0000;
        launch(15'h7FFE, 16'd4);
        wait_done(50, 1'b0, seen);
        total++; if (!seen) begin bad++; $display("FAIL wrap_done: got timeout want done"); end
        total++; if (exp_addr.size() != 0) begin bad++; $display("FAIL wrap_reads: got %0d left want 0", exp_addr.size()); end
        step();
    endtask

    task automatic test_stall();
        bit seen;
        int x0;
        mem_key       = 32'hA5A5_0000;
        bus.src_ready = 1'b0;
        read_count    = 0;
        x0            = xfer_count;
        launch(15'h0200, 16'd20);
        repeat (10) step();
        total++; if (read_count != int'(DEPTH)) begin bad++; $display("FAIL stall_reads: got %0d want %0d", read_count, DEPTH); end
        total++; if (bus.src_valid !== 1'b1)    begin bad++; $display("FAIL stall_valid: got %b want 1", bus.src_valid); end
        bus.src_ready = 1'b1;
        wait_done(200, 1'b0, seen);
        total++; if (!seen) begin bad++; $display("FAIL stall_done: got timeout want done"); end
        total++; if (xfer_count - x0 != 20) begin bad++; $display("FAIL stall_words: got %0d want 20", xfer_count - x0); end
        step();
    endtask

    task automatic test_zero_len();
        bit seen = 1'b0;
        read_count = 0;
        launch(15'h0055, 16'd0);
        for (int k = 0; k < 2; k++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            if (!seen) step();
        end
        if (bus.done === 1'b1) seen = 1'b1;
        total++; if (!seen) begin bad++; $display("FAIL zero_done: got no pulse want pulse within 2"); end
        step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", bus.busy); end
        total++; if (read_count != 0)   begin bad++; $display("FAIL zero_reads: got %0d want 0", read_count); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit hit = 1'b0;
        int x0;
        mem_key       = 32'h0F0F_0000;
        bus.src_ready = 1'b1;
        x0            = xfer_count;
        launch(15'h0300, 16'd16);
        for (int k = 0; k < 100 && !hit; k++) begin
            if (xfer_count - x0 >= 5) hit = 1'b1;
            else step();
        end
        total++; if (!hit) begin bad++; $display("FAIL mid_progress: got %0d words want 5", xfer_count - x0); end
        reset = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        step();
        total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0)      begin bad++; $display("FAIL mid_done: got %b want 0", bus.done); end
        total++; if (bus.avm_read !== 1'b0)  begin bad++; $display("FAIL mid_read: got %b want 0", bus.avm_read); end
        total++; if (bus.src_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", bus.src_valid); end
        reset = 1'b0;
        launch(15'h0100, 16'd2);
        wait_done(50, 1'b0, seen);
        total++; if (!seen) begin bad++; $display("FAIL mid_restart: got timeout want done"); end
        total++; if (exp_data.size() != 0) begin bad++; $display("FAIL mid_left: got %0d want 0", exp_data.size()); end
        step();
    endtask

    task automatic test_busy_start();
        bit seen;
        mem_key       = 32'h7777_0000;
        bus.src_ready = 1'b1;
        launch(15'h0400, 16'd8);
        step();
        bus.start     = 1'b1;
        bus.base_addr = 15'h0999;
        bus.length    = 16'd3;
        step();
        bus.start = 1'b0;
        wait_done(100, 1'b0, seen);
        total++; if (!seen) begin bad++; $display("FAIL busy_done: got timeout want done"); end
        total++; if (exp_data.size() != 0) begin bad++; $display("FAIL busy_left: got %0d want 0", exp_data.size()); end
        repeat (3) step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_ignored: got %b want 0", bus.busy); end
    endtask

    task automatic test_random();
        bit seen;
        int x0;
        mem_key = $urandom;
        x0      = xfer_count;
        launch(ADDR_W'($urandom), 16'd1000);
        wait_done(20000, 1'b1, seen);
        total++; if (!seen) begin bad++; $display("FAIL rand_done: got timeout want done"); end
        total++; if (xfer_count - x0 != 1000) begin bad++; $display("FAIL rand_words: got %0d want 1000", xfer_count - x0); end
        total++; if (exp_data.size() != 0) begin bad++; $display("FAIL rand_left: got %0d want 0", exp_data.size()); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_busy_start();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avmm_block_reader.md
AVMM_BLOCK_READER -- requirements
Module: avmm_block_reader

Interface
REQ-001 Parameter ADDR_W, default 15, word-address width of the Avalon-MM master port.
REQ-002 Parameter READ_LATENCY, default 1, fixed cycles from read issue to valid avm_readdata.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer depth in words, power of two, >= READ_LATENCY+1.
REQ-004 One clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a block read; ignored while busy=1.
REQ-008 base_addr  in  ADDR_W  first word address, sampled when start is accepted.
REQ-009 length  in  ADDR_W+1  word count 0..2^ADDR_W, sampled when start is accepted.
REQ-010 busy  out  1  high from the cycle after start is accepted until done.
REQ-011 done  out  1  one-cycle pulse when the block completes.
REQ-012 avm_address  out  ADDR_W  word address of the current read.
REQ-013 avm_chipselect  out  1  asserted together with avm_read.
REQ-014 avm_read  out  1  one word read per asserted cycle; the slave has no waitrequest.
REQ-015 avm_write  out  1  tied 0; avm_byteenable out 4 tied 4'hF; avm_writedata out 32 tied 0.
REQ-016 avm_readdata  in  32  read data, valid exactly READ_LATENCY cycles after the issue cycle.
REQ-017 src_data  out  32  streamed word, equal to FIFO head.
REQ-018 src_valid  out  1  FIFO not empty.
REQ-019 src_ready  in  1  sink accepts; a transfer occurs when src_valid & src_ready.

Function
REQ-020 FSM states are IDLE, ISSUE, DRAIN; reset enters IDLE.
REQ-021 In IDLE, start=1 latches base_addr/length, clears the issue counter, and moves to ISSUE; if length=0, it moves directly to DRAIN.
REQ-022 In ISSUE, a read is issued in a cycle iff fifo_count + outstanding < FIFO_DEPTH (credit rule); the FIFO never overflows.
REQ-023 Issued address = base_addr + issue_index, modulo 2^ADDR_W (wrap 0x7FFF -> 0x0000).
REQ-024 After the length-th read is issued, the FSM moves to DRAIN in the next cycle.
REQ-025 outstanding is a shift register of READ_LATENCY valid bits; the bit leaving the shift register writes avm_readdata into the FIFO the same cycle.
REQ-026 In DRAIN, when outstanding=0 and the FIFO is empty (or becomes empty via the current transfer), done pulses for 1 cycle, busy clears in the same cycle, and the FSM returns to IDLE.
REQ-027 done must not pulse before the last word has transferred on the stream port.
REQ-028 A simultaneous FIFO push and pop keeps fifo_count unchanged; a pop of the last word with a push in the same cycle keeps src_valid=1.
REQ-029 With src_ready held at 1 and READ_LATENCY=1, throughput is one word per cycle after the first word; the first word appears on src_valid 2 cycles after start.
REQ-030 Stream order equals address order; src_data stays stable while src_valid=1 and src_ready=0.

Reset
REQ-031 Reset forces IDLE, busy=0, done=0, avm_read=0, avm_chipselect=0, src_valid=0, outstanding=0, and FIFO empty, and drops any in-flight read data.
REQ-032 Reset mid-block aborts without a done pulse; start in the first post-reset cycle is accepted normally.

Structure
REQ-033 Package avmm_reader_pkg holds the state enum type, the default ADDR_W/FIFO_DEPTH constants, and the data width constant 32.
REQ-034 Sub-module avmm_reader_fifo is a synchronous FWFT FIFO (push, pop, count, data) with parameters WIDTH and DEPTH and the same reset.

Verification
REQ-035 base=0x0010, length=4, src_ready=1, memory[a]=a -> reads at 0x10..0x13 on 4 consecutive cycles, stream 0x10..0x13, done pulse one cycle after the last transfer.
REQ-036 base=0x7FFE, length=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001 in that order.
REQ-037 length=20, src_ready=0 for 10 cycles then 1 -> exactly FIFO_DEPTH reads issued while stalled, no overflow, all 20 words in order.
REQ-038 length=0 -> no avm_read, done pulses within 2 cycles, busy returns to 0.
REQ-039 reset asserted during a length=16 block after 5 transfers -> all outputs at reset values the next cycle, no done pulse; a new start with base=0x0100, length=2 then completes correctly.
REQ-040 start pulsed while busy -> ignored; the block in progress completes unchanged; random src_ready over 1000 words -> the scoreboard matches the memory image.
